// File: rtl/tholin_bus_target.sv
// tholin_bus_target: pad-side responder for the Tholin 16-bit multiplexed external bus.
// Captures the address from the latch-enable phases, answers OEb reads after RD_LAT wait cycles,
// and merges WEb_lo/WEb_hi byte-lane writes into a DEPTH x 16 word store.
// Ports: wb_clk_i/wb_rst_i clock and async active-high reset; bus_in address/data from the initiator;
//   bus_out/bus_oe read data and pad output enable; le_lo/le_hi address latch enables;
//   OEb, WEb_lo, WEb_hi active-low strobes; hit = latched address[31:16] matches BASE_HI;
//   err = sticky protocol error, cleared only by reset.
module tholin_bus_target #(
  parameter int          ADDR_W  = 8,
  parameter logic [15:0] BASE_HI = 16'h0000,
  parameter int          RD_LAT  = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] bus_in,
  output logic [15:0] bus_out,
  output logic        bus_oe,
  input  logic        le_lo,
  input  logic        le_hi,
  input  logic        OEb,
  input  logic        WEb_lo,
  input  logic        WEb_hi,
  output logic        hit,
  output logic        err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RD_DRIVE = 2'd2,
    WR       = 2'd3
  } state_t;

  // Address latch: only the word-index bits of the low half are kept, addr[0] is a byte offset.
  logic [ADDR_W-1:0] aidx_q;
  logic [15:0]       ahi_q;

  // Single-stage sampling of strobes and data; the FSM only looks at these.
  logic              s_oeb_q;
  logic              s_weblo_q;
  logic              s_webhi_q;
  logic [15:0]       s_bus_q;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] idx_q;      // index frozen when an access leaves IDLE
  logic [7:0]        wlo_q;
  logic [7:0]        whi_q;
  logic              mlo_q;
  logic              mhi_q;
  logic [15:0]       bus_out_q;
  logic              bus_oe_q;
  logic              err_q;

  logic [15:0]       mem [DEPTH];

  logic              commit_d;
  logic              any_web_lo;

  assign hit        = (ahi_q == BASE_HI);
  assign any_web_lo = !s_weblo_q || !s_webhi_q;

  // A write lands once both sampled strobes are back high. Gating with reset keeps an
  // in-flight write from landing on the edge where reset is still asserted.
  assign commit_d = (state_q == WR) && s_weblo_q && s_webhi_q && !wb_rst_i;

  always_ff @(posedge wb_clk_i) begin
    if (commit_d) begin
      if (mlo_q) mem[idx_q][7:0]  <= wlo_q;
      if (mhi_q) mem[idx_q][15:8] <= whi_q;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      aidx_q    <= '0;
      ahi_q     <= '0;
      s_oeb_q   <= 1'b1;
      s_weblo_q <= 1'b1;
      s_webhi_q <= 1'b1;
      s_bus_q   <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wlo_q     <= '0;
      whi_q     <= '0;
      mlo_q     <= 1'b0;
      mhi_q     <= 1'b0;
      bus_out_q <= '0;
      bus_oe_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      s_oeb_q   <= OEb;
      s_weblo_q <= WEb_lo;
      s_webhi_q <= WEb_hi;
      s_bus_q   <= bus_in;

      // The latch follows the pins even mid-access; the access itself uses idx_q.
      if (le_lo) aidx_q <= bus_in[ADDR_W:1];
      if (le_hi) ahi_q  <= bus_in;
      if ((le_lo || le_hi) && (state_q != IDLE)) err_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (!s_oeb_q && any_web_lo) begin
            err_q <= 1'b1;
          end else if (hit && !s_oeb_q) begin
            idx_q <= aidx_q;
            if (RD_LAT == 0) begin
              bus_out_q <= mem[aidx_q];
              bus_oe_q  <= 1'b1;
              state_q   <= RD_DRIVE;
            end else begin
              cnt_q   <= 4'(RD_LAT - 1);
              state_q <= RD_WAIT;
            end
          end else if (hit && any_web_lo) begin
            // Capture lanes already here so a single-cycle strobe still writes.
            idx_q   <= aidx_q;
            state_q <= WR;
            if (!s_weblo_q) begin
              wlo_q <= s_bus_q[7:0];
              mlo_q <= 1'b1;
            end
            if (!s_webhi_q) begin
              whi_q <= s_bus_q[15:8];
              mhi_q <= 1'b1;
            end
          end
        end

        RD_WAIT: begin
          if (s_oeb_q) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            bus_out_q <= mem[idx_q];
            bus_oe_q  <= 1'b1;
            state_q   <= RD_DRIVE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        RD_DRIVE: begin
          if (s_oeb_q) begin
            bus_oe_q <= 1'b0;
            state_q  <= IDLE;
          end
        end

        WR: begin
          if (!s_oeb_q) err_q <= 1'b1;
          if (!s_weblo_q) begin
            wlo_q <= s_bus_q[7:0];
            mlo_q <= 1'b1;
          end
          if (!s_webhi_q) begin
            whi_q <= s_bus_q[15:8];
            mhi_q <= 1'b1;
          end
          if (s_weblo_q && s_webhi_q) begin
            mlo_q   <= 1'b0;
            mhi_q   <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_out = bus_out_q;
  assign bus_oe  = bus_oe_q;
  assign err     = err_q;

endmodule

// File: tb/tb_tholin_bus_target.sv
// tb_tholin_bus_target: three target instances (RD_LAT 2 / 4 / 0, the second with BASE_HI 0x8000)
// share one stimulus bus; only the selected instance sees live strobes and latch enables.
// A word-level model (memory array + latched address + sticky error) predicts every output each cycle.
module tb_tholin_bus_target;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        le_lo, le_hi, oeb, weblo, webhi;
  int          sel;

  logic [15:0] bo   [N];
  logic        boe  [N];
  logic        hitw [N];
  logic        errw [N];

  int          lat_m  [N] = '{2, 4, 0};
  logic [15:0] base_m [N] = '{16'h0000, 16'h8000, 16'h0000};

  // Model state
  logic [15:0] mem_m [N][256];
  logic [15:0] ahi_m [N];
  logic [7:0]  idx_m [N];
  logic        err_m [N];
  logic        exp_oe;
  logic [15:0] exp_dat;
  logic        run_chk = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  tholin_bus_target #(.ADDR_W(8), .BASE_HI(16'h0000), .RD_LAT(2)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus_in(bus_in), .bus_out(bo[0]), .bus_oe(boe[0]),
    .le_lo(le_lo && sel == 0), .le_hi(le_hi && sel == 0),
    .OEb(oeb || sel != 0), .WEb_lo(weblo || sel != 0), .WEb_hi(webhi || sel != 0),
    .hit(hitw[0]), .err(errw[0]));

  tholin_bus_target #(.ADDR_W(8), .BASE_HI(16'h8000), .RD_LAT(4)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus_in(bus_in), .bus_out(bo[1]), .bus_oe(boe[1]),
    .le_lo(le_lo && sel == 1), .le_hi(le_hi && sel == 1),
    .OEb(oeb || sel != 1), .WEb_lo(weblo || sel != 1), .WEb_hi(webhi || sel != 1),
    .hit(hitw[1]), .err(errw[1]));

  tholin_bus_target #(.ADDR_W(8), .BASE_HI(16'h0000), .RD_LAT(0)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus_in(bus_in), .bus_out(bo[2]), .bus_oe(boe[2]),
    .le_lo(le_lo && sel == 2), .le_hi(le_hi && sel == 2),
    .OEb(oeb || sel != 2), .WEb_lo(weblo || sel != 2), .WEb_hi(webhi || sel != 2),
    .hit(hitw[2]), .err(errw[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, sel=%0d)", name, act, exp, $time, sel);
  endtask

  // Per-cycle comparison of all instances against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      for (int i = 0; i < N; i++) begin
        chk("bus_oe", {31'd0, boe[i]}, {31'd0, (i == sel) ? exp_oe : 1'b0});
        if (i == sel && exp_oe) chk("bus_out", {16'd0, bo[i]}, {16'd0, exp_dat});
        chk("err", {31'd0, errw[i]}, {31'd0, err_m[i]});
        chk("hit", {31'd0, hitw[i]}, {31'd0, ahi_m[i] == base_m[i]});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      err_m[i] = 1'b0;
      ahi_m[i] = 16'h0000;
      idx_m[i] = 8'h00;
    end
    exp_oe = 1'b0;
  endtask

  task automatic set_addr(input logic [31:0] a);
    bus_in = a[31:16];
    le_hi  = 1'b1;
    tick();
    ahi_m[sel] = a[31:16];
    le_hi  = 1'b0;
    bus_in = a[15:0];
    le_lo  = 1'b1;
    tick();
    idx_m[sel] = a[8:1];
    le_lo  = 1'b0;
  endtask

  // Strobes held low for n edges; the store is updated two edges after release.
  task automatic do_write(input logic [15:0] d, input logic lo, input logic hi, input int n);
    bus_in = d;
    weblo  = !lo;
    webhi  = !hi;
    repeat (n) tick();
    weblo = 1'b1;
    webhi = 1'b1;
    tick();
    tick();
    if (ahi_m[sel] == base_m[sel]) begin
      if (lo) mem_m[sel][idx_m[sel]][7:0]  = d[7:0];
      if (hi) mem_m[sel][idx_m[sel]][15:8] = d[15:8];
    end
  endtask

  // OEb low; bus_oe expected from edge E(1+RD_LAT) until the second edge with OEb high.
  // want >= 0 adds a hand-computed literal check of the returned word.
  task automatic do_read(input int hold, input logic poke, input logic [15:0] poke_addr, input int want);
    logic h;
    h   = (ahi_m[sel] == base_m[sel]);
    oeb = 1'b0;
    tick();
    for (int k = 1; k <= 1 + lat_m[sel]; k++) begin
      tick();
      if (k == 1 + lat_m[sel] && h) begin
        exp_oe  = 1'b1;
        exp_dat = mem_m[sel][idx_m[sel]];
      end
    end
    if (want >= 0) chk("read_data", {16'd0, bo[sel]}, {16'd0, want[15:0]});
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 0) begin
        bus_in = poke_addr;
        le_lo  = 1'b1;
      end
      tick();
      if (poke && k == 0) begin
        le_lo      = 1'b0;
        idx_m[sel] = poke_addr[8:1];
        if (h) err_m[sel] = 1'b1;
      end
    end
    oeb = 1'b1;
    tick();
    tick();
    exp_oe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d4 [4];
    d4 = '{16'hC0DE, 16'h5A5A, 16'h0F0F, 16'h3C21};

    rst = 1'b1; bus_in = 16'h0000; le_lo = 1'b0; le_hi = 1'b0;
    oeb = 1'b1; weblo = 1'b1; webhi = 1'b1; sel = 0;
    model_reset();
    tick();
    tick();
    chk("reset_bus_oe0", {31'd0, boe[0]}, 32'd0);
    chk("reset_bus_out0", {16'd0, bo[0]}, 32'h0);
    chk("reset_err0", {31'd0, errw[0]}, 32'd0);
    chk("reset_hit0", {31'd0, hitw[0]}, 32'd1);
    chk("reset_hit1", {31'd0, hitw[1]}, 32'd0);
    rst = 1'b0;
    run_chk = 1'b1;
    tick();

    // Instance 0: RD_LAT=2, BASE_HI=0
    set_addr(32'h0000_0010);
    do_write(16'hBEEF, 1'b1, 1'b1, 3);
    do_read(2, 1'b0, 16'h0, 16'hBEEF);
    do_write(16'h12A5, 1'b1, 1'b0, 3);
    do_read(1, 1'b0, 16'h0, 16'hBEA5);
    do_write(16'h7700, 1'b0, 1'b1, 2);
    do_read(1, 1'b0, 16'h0, 16'h77A5);

    // Latch enable during RD_DRIVE: error, data held
    do_read(3, 1'b1, 16'h0020, 16'h77A5);
    chk("le_in_drive_err", {31'd0, errw[0]}, 32'd1);

    // Reset in the middle of RD_DRIVE
    set_addr(32'h0000_0010);
    oeb = 1'b0;
    tick();
    repeat (3) tick();
    exp_oe  = 1'b1;
    exp_dat = mem_m[0][8];
    tick();
    rst = 1'b1;
    #1;
    chk("async_rst_bus_oe", {31'd0, boe[0]}, 32'd0);
    chk("async_rst_err", {31'd0, errw[0]}, 32'd0);
    chk("async_rst_bus_out", {16'd0, bo[0]}, 32'h0);
    model_reset();
    oeb = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // OEb and WEb_lo together: sticky error, no access
    set_addr(32'h0000_0010);
    oeb = 1'b0; weblo = 1'b0; bus_in = 16'hFFFF;
    tick();
    tick();
    err_m[0] = 1'b1;
    oeb = 1'b1; weblo = 1'b1;
    tick();
    tick();
    chk("collision_err", {31'd0, errw[0]}, 32'd1);
    do_read(1, 1'b0, 16'h0, 16'h77A5);
    chk("err_sticky", {31'd0, errw[0]}, 32'd1);

    // Instance 1: RD_LAT=4, BASE_HI=0x8000
    sel = 1;
    tick();
    set_addr(32'h8000_0010);
    do_write(16'h1234, 1'b1, 1'b1, 2);
    do_read(1, 1'b0, 16'h0, 16'h1234);
    // Abort during the wait phase: bus_oe must never rise
    oeb = 1'b0;
    repeat (3) tick();
    oeb = 1'b1;
    repeat (5) tick();
    chk("abort_err", {31'd0, errw[1]}, 32'd0);
    // Miss: upper address does not match
    set_addr(32'h0000_0010);
    chk("miss_hit", {31'd0, hitw[1]}, 32'd0);
    do_write(16'hDEAD, 1'b1, 1'b1, 2);
    do_read(1, 1'b0, 16'h0, -1);
    set_addr(32'h8000_0010);
    do_read(1, 1'b0, 16'h0, 16'h1234);
    chk("miss_err", {31'd0, errw[1]}, 32'd0);

    // Instance 2: RD_LAT=0, single-cycle write strobes to words 0..3, then reads
    sel = 2;
    tick();
    for (int i = 0; i < 4; i++) begin
      set_addr(32'(2 * i));
      do_write(d4[i], 1'b1, 1'b1, 1);
    end
    for (int i = 0; i < 4; i++) begin
      set_addr(32'(2 * i));
      do_read(0, 1'b0, 16'h0, int'(d4[i]));
    end

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
